seg7_bcd_counter_mux: RTL

Parametrised multi-digit BCD counter that drives a time-multiplexed common-select 7-segment display.
- One clock domain; derives a single-cycle count tick and a digit-scan strobe from the system clock. No generated clocks.
- Supports up/down counting, enable, synchronous parallel load, wrap flag and optional leading-zero blanking.
- Sits between board push-buttons/switches and the 7-segment pins.

---
 rtl/seg7_bcd_counter_mux.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with load, wrap pulse and a time-multiplexed
// common-select 7-segment driver; tick and scan strobes are derived from one clock.
module seg7_bcd_counter_mux #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned SCAN_HZ         = 1000,
    parameter bit          COM_ACTIVE_HIGH = 1'b1,
    parameter bit          BLANK_LEADING   = 1'b1
) (
    input  logic                  CLK_50MHz,
    input  logic                  Res,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic                  TICK,
    output logic                  WRAP,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     SEG_COM
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIGITS-1:0] COM_ONE = DIGITS'(1);
    localparam logic [DIGITS-1:0] COM_RST = COM_ACTIVE_HIGH ? COM_ONE : ~COM_ONE;

    logic [TW-1:0]         tick_cnt_q;
    logic                  tick_q;
    logic [SW-1:0]         scan_cnt_q;
    logic [IW-1:0]         digit_q;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     com_q, com_d;

    logic                  carry;
    logic [3:0]            nib;
    logic [3:0]            nib_sel;
    logic                  upper_nz;
    logic                  blank;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     com_onehot;

    // Tick divider and scan timing: free-running, independent of EN.
    always_ff @(posedge CLK_50MHz or negedge Res) begin
        if (!Res) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            scan_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            tick_q <= (tick_cnt_q == TW'(TICK_DIV - 1));
            if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
            end

            if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                if (digit_q == IW'(DIGITS - 1)) begin
                    digit_q <= '0;
                end else begin
                    digit_q <= digit_q + IW'(1);
                end
            end else begin
                scan_cnt_q <= scan_cnt_q + SW'(1);
            end
        end
    end

    // Load wins over a coincident tick; out-of-range load nibbles clamp to 9.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        nib     = 4'd0;
        if (LOAD) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                nib = LOAD_VAL[i*4 +: 4];
                count_d[i*4 +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end else if (tick_q && EN) begin
            carry = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                nib = count_q[i*4 +: 4];
                if (carry) begin
                    if (UP) begin
                        if (nib == 4'd9) begin
                            count_d[i*4 +: 4] = 4'd0;
                        end else begin
                            count_d[i*4 +: 4] = nib + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            count_d[i*4 +: 4] = 4'd9;
                        end else begin
                            count_d[i*4 +: 4] = nib - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        nib_sel  = 4'd0;
        upper_nz = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == digit_q) begin
                nib_sel = count_q[i*4 +: 4];
            end
            if ((IW'(i) >= digit_q) && (count_q[i*4 +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        blank = BLANK_LEADING && (digit_q != '0) && !upper_nz;

        case (nib_sel)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1011000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0011000;
            default: glyph = 7'b1111111;
        endcase

        seg_d      = blank ? 7'b1111111 : glyph;
        com_onehot = COM_ONE << digit_q;
        com_d      = COM_ACTIVE_HIGH ? com_onehot : ~com_onehot;
    end

    always_ff @(posedge CLK_50MHz or negedge Res) begin
        if (!Res) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= 7'b1000000;
            com_q   <= COM_RST;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            com_q   <= com_d;
        end
    end

    assign COUNT   = count_q;
    assign TICK    = tick_q;
    assign WRAP    = wrap_q;
    assign SEG     = seg_q;
    assign SEG_COM = com_q;

endmodule
